div_unit: RTL

- Multi-cycle signed/unsigned integer divider for the execute stage of the 5-stage MIPS pipeline.
- Consumes the DIV/DIVU operation decoded by the controller (alucontrolE) and the forwarded rs/rt operands.
- Produces {HI, LO} for the HI/LO write path (hilowriteE/M/W).
- Raises a stall request that the hazard unit turns into stallE and stalls upstream until the quotient is ready.

---
 rtl/div_unit_pkg.sv | 18 +
 rtl/div_unit.sv | 153 +++++++++++++++
 2 files changed

// File: rtl/div_unit_pkg.sv
// Shared definitions for the execute-stage multi-cycle divider.
package div_unit_pkg;

  // Default operand width of the MIPS datapath
  localparam int DIV_WIDTH = 32;

  // alucontrolE codes for the divide operations, alongside the other ALU ops
  localparam logic [4:0] ALU_DIV  = 5'b10000;
  localparam logic [4:0] ALU_DIVU = 5'b10001;

  // Divider sequencer states
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_DIV  = 2'd1,
    ST_DONE = 2'd2
  } div_state_e;

endpackage

// File: rtl/div_unit.sv
// Multi-cycle restoring divider for DIV/DIVU in the E stage.
// Produces {HI = remainder, LO = quotient} one quotient bit per cycle and
// requests a pipeline stall until the result is ready.
module div_unit
  import div_unit_pkg::*;
#(
  parameter int WIDTH = DIV_WIDTH,
  parameter int CNT_W = $clog2(WIDTH) + 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               signed_div,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  input  logic               annul,
  output logic               stall_o,
  output logic               ready,
  output logic [2*WIDTH-1:0] result
);

  localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(WIDTH - 1);

  div_state_e         state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [WIDTH-1:0]   rem_q, rem_d;
  logic [WIDTH-1:0]   quo_q, quo_d;
  logic [WIDTH-1:0]   dvsr_q, dvsr_d;
  logic               qneg_q, qneg_d;
  logic               rneg_q, rneg_d;
  logic [2*WIDTH-1:0] result_q, result_d;

  logic               go;
  logic               last_iter;
  logic               a_neg, b_neg, b_zero;
  logic [WIDTH:0]     shifted, trial;
  logic               trial_ok;
  logic [WIDTH-1:0]   step_rem, step_quo;
  logic [WIDTH-1:0]   fix_rem, fix_quo;

  assign go        = start & ~annul;
  assign last_iter = (cnt_q == LAST_ITER);
  assign result    = result_q;

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic: annul always wins over completion
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (go) state_d = ST_DIV;
      ST_DIV: begin
        if (annul)          state_d = ST_IDLE;
        else if (last_iter) state_d = ST_DONE;
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Outputs: stall is combinational so the E stage freezes in the start cycle
  always_comb begin
    stall_o = 1'b0;
    ready   = 1'b0;
    case (state_q)
      ST_IDLE: stall_o = go;
      ST_DIV:  stall_o = 1'b1;
      ST_DONE: ready   = 1'b1;
      default: ;
    endcase
  end

  // Operand conditioning; a zero divisor keeps the quotient positive so LO stays all-ones
  always_comb begin
    a_neg  = signed_div & a[WIDTH-1];
    b_neg  = signed_div & b[WIDTH-1];
    b_zero = (b == '0);
  end

  // One restoring step plus the sign fix-up applied on the final iteration
  always_comb begin
    shifted  = {rem_q, quo_q[WIDTH-1]};
    trial    = shifted - {1'b0, dvsr_q};
    trial_ok = ~trial[WIDTH];
    step_rem = trial_ok ? trial[WIDTH-1:0] : shifted[WIDTH-1:0];
    step_quo = {quo_q[WIDTH-2:0], trial_ok};
    fix_quo  = qneg_q ? -step_quo : step_quo;
    fix_rem  = rneg_q ? -step_rem : step_rem;
  end

  // Datapath next values: latch operands on start, iterate in DIV, capture result on completion
  always_comb begin
    cnt_d    = cnt_q;
    rem_d    = rem_q;
    quo_d    = quo_q;
    dvsr_d   = dvsr_q;
    qneg_d   = qneg_q;
    rneg_d   = rneg_q;
    result_d = result_q;
    case (state_q)
      ST_IDLE: begin
        if (go) begin
          cnt_d  = '0;
          rem_d  = '0;
          quo_d  = a_neg ? -a : a;
          dvsr_d = b_neg ? -b : b;
          qneg_d = (a_neg ^ b_neg) & ~b_zero;
          rneg_d = a_neg;
        end
      end
      ST_DIV: begin
        if (!annul) begin
          cnt_d = cnt_q + CNT_W'(1);
          rem_d = step_rem;
          quo_d = step_quo;
          if (last_iter) begin
            result_d = {fix_rem, fix_quo};
          end
        end
      end
      default: ;
    endcase
  end

  // Datapath registers
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q    <= '0;
      rem_q    <= '0;
      quo_q    <= '0;
      dvsr_q   <= '0;
      qneg_q   <= 1'b0;
      rneg_q   <= 1'b0;
      result_q <= '0;
    end else begin
      cnt_q    <= cnt_d;
      rem_q    <= rem_d;
      quo_q    <= quo_d;
      dvsr_q   <= dvsr_d;
      qneg_q   <= qneg_d;
      rneg_q   <= rneg_d;
      result_q <= result_d;
    end
  end

endmodule
